// File: rtl/ad7476_sample_packer.sv
// AD7476 capture engine: paces CSn/SCLK frames from a free-running sample timer
// and packs pairs of 12-bit conversions into 32-bit receive-FIFO words.
//
// state    | meaning
// IDLE     | disabled, CSn/SCLK high, sticky flags clear while enable is low
// WAIT     | enabled, waiting for the sample timer terminal count
// CONV     | CSn low, 16 SCLK periods shifting SDATA in MSB first
// QUIET    | CSn high for the quiet time before the next WAIT
module ad7476_sample_packer #(
   parameter int SCLK_DIV      = 2,
   parameter int SAMPLE_PERIOD = 80,
   parameter int QUIET_CYCLES  = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        enable_i,
   input  logic        rx_fifo_full_i,
   output logic        spi_ss_o,
   output logic        spi_sck_o,
   input  logic        spi_miso_i,
   output logic [31:0] sample_data_o,
   output logic        sample_push_o,
   output logic        overrun_o,
   output logic        frame_err_o,
   output logic [1:0]  fsm_st_o
);

   localparam int TMR_W = $clog2(SAMPLE_PERIOD);
   localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam int QCW   = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_RELOAD   = TMR_W'(SAMPLE_PERIOD - 1);
   localparam logic [DIV_W-1:0] DIV_RELOAD   = DIV_W'(SCLK_DIV - 1);
   localparam logic [QCW-1:0]   QUIET_RELOAD = QCW'(QUIET_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_CONV  = 2'd2,
      ST_QUIET = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [QCW-1:0]   quiet_q, quiet_d;
   logic [3:0]       bit_q, bit_d;
   logic [15:0]      shift_q, shift_d;
   logic             full_q, full_d;
   logic             pair_q, pair_d;
   logic [11:0]      s0_q, s0_d;
   logic             ss_q, ss_d;
   logic             sck_q, sck_d;
   logic [31:0]      data_q, data_d;
   logic             push_q, push_d;
   logic             ovr_q, ovr_d;
   logic             ferr_q, ferr_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         tmr_q   <= '0;
         div_q   <= '0;
         quiet_q <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         full_q  <= 1'b0;
         pair_q  <= 1'b0;
         s0_q    <= '0;
         ss_q    <= 1'b1;
         sck_q   <= 1'b1;
         data_q  <= '0;
         push_q  <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         div_q   <= div_d;
         quiet_q <= quiet_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         full_q  <= full_d;
         pair_q  <= pair_d;
         s0_q    <= s0_d;
         ss_q    <= ss_d;
         sck_q   <= sck_d;
         data_q  <= data_d;
         push_q  <= push_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      div_d   = div_q;
      quiet_d = quiet_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      full_d  = full_q;
      pair_d  = pair_q;
      s0_d    = s0_q;
      ss_d    = ss_q;
      sck_d   = sck_q;
      data_d  = data_q;
      push_d  = 1'b0;
      ovr_d   = ovr_q;
      ferr_d  = ferr_q;

      // Sample timer free-runs while enabled so frame spacing is independent of frame length.
      if (state_q != ST_IDLE)
         tmr_d = (tmr_q == '0) ? TMR_RELOAD : tmr_q - TMR_W'(1);

      if (!enable_i) begin
         state_d = ST_IDLE;
         tmr_d   = '0;
         ss_d    = 1'b1;
         sck_d   = 1'b1;
         pair_d  = 1'b0;
         if (state_q == ST_IDLE) begin
            ovr_d  = 1'b0;
            ferr_d = 1'b0;
         end
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_WAIT;
               tmr_d   = '0;
            end
            ST_WAIT: begin
               if (tmr_q == '0) begin
                  state_d = ST_CONV;
                  ss_d    = 1'b0;
                  sck_d   = 1'b0;
                  div_d   = DIV_RELOAD;
                  bit_d   = 4'd15;
               end
            end
            ST_CONV: begin
               if (div_q != '0) begin
                  div_d = div_q - DIV_W'(1);
               end else begin
                  div_d = DIV_RELOAD;
                  if (!sck_q) begin
                     sck_d   = 1'b1;
                     shift_d = {shift_q[14:0], spi_miso_i};
                     if (bit_q == 4'd0)
                        full_d = rx_fifo_full_i;
                  end else if (bit_q == 4'd0) begin
                     state_d = ST_QUIET;
                     ss_d    = 1'b1;
                     quiet_d = QUIET_RELOAD;
                     if (shift_q[15:12] != 4'd0)
                        ferr_d = 1'b1;
                     if (!pair_q) begin
                        s0_d   = shift_q[11:0];
                        pair_d = 1'b1;
                     end else begin
                        pair_d = 1'b0;
                        if (full_q) begin
                           ovr_d = 1'b1;
                        end else begin
                           data_d = {4'h0, shift_q[11:0], 4'h0, s0_q};
                           push_d = 1'b1;
                        end
                     end
                  end else begin
                     sck_d = 1'b0;
                     bit_d = bit_q - 4'd1;
                  end
               end
            end
            ST_QUIET: begin
               if (quiet_q == '0)
                  state_d = ST_WAIT;
               else
                  quiet_d = quiet_q - QCW'(1);
            end
         endcase
      end
   end

   assign spi_ss_o      = ss_q;
   assign spi_sck_o     = sck_q;
   assign sample_data_o = data_q;
   assign sample_push_o = push_q;
   assign overrun_o     = ovr_q;
   assign frame_err_o   = ferr_q;
   assign fsm_st_o      = state_q;

endmodule

// File: tb/tb_ad7476_sample_packer.sv
// Directed and randomized bench for ad7476_sample_packer with an ADC model
// and a frame-level scoreboard of packed words and sticky flags.
module tb_ad7476_sample_packer;

   localparam int SCLK_DIV      = 2;
   localparam int SAMPLE_PERIOD = 80;
   localparam int QUIET_CYCLES  = 2;
   localparam int FRAME_LOW     = 32 * SCLK_DIV;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        enable_i = 1'b0;
   logic        rx_fifo_full_i = 1'b0;
   logic        spi_miso_i = 1'b0;
   logic        spi_ss_o, spi_sck_o, sample_push_o, overrun_o, frame_err_o;
   logic [31:0] sample_data_o;
   logic [1:0]  fsm_st_o;

   int n_checks = 0;
   int n_err    = 0;
   logic [15:0] adc_q[$];

   always #5 clk_i = ~clk_i;

   ad7476_sample_packer #(
      .SCLK_DIV     (SCLK_DIV),
      .SAMPLE_PERIOD(SAMPLE_PERIOD),
      .QUIET_CYCLES (QUIET_CYCLES)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .enable_i      (enable_i),
      .rx_fifo_full_i(rx_fifo_full_i),
      .spi_ss_o      (spi_ss_o),
      .spi_sck_o     (spi_sck_o),
      .spi_miso_i    (spi_miso_i),
      .sample_data_o (sample_data_o),
      .sample_push_o (sample_push_o),
      .overrun_o     (overrun_o),
      .frame_err_o   (frame_err_o),
      .fsm_st_o      (fsm_st_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: frame words are served by the ADC model; completed frames pair up into words.
   int          cyc = 0, last_fall = 0, low_cnt = 0, rises = 0;
   bit          fall_valid = 0, en_prev = 0, ss_prev = 1, sck_prev = 1;
   bit          m_phase = 0, m_ovr = 0, m_ferr = 0, m_push = 0, cap_full = 0;
   logic [15:0] cur_word = '0;
   logic [11:0] m_s0 = '0;
   logic [31:0] m_data = '0;

   always @(posedge clk_i) begin
      #1;
      cyc++;
      if (rst_i) begin
         m_phase = 0; m_ovr = 0; m_ferr = 0; m_data = '0; m_push = 0;
         fall_valid = 0; en_prev = 0; ss_prev = 1; sck_prev = 1;
         low_cnt = 0; rises = 0; spi_miso_i = 1'b0;
      end else begin
         m_push = 0;
         if (!enable_i) begin
            m_phase = 0;
            fall_valid = 0;
            if (!en_prev) begin
               m_ovr = 0;
               m_ferr = 0;
            end
         end
         if (ss_prev && !spi_ss_o) begin
            if (fall_valid) chk("ss_fall_spacing", cyc - last_fall, SAMPLE_PERIOD);
            last_fall = cyc; fall_valid = 1; low_cnt = 0; rises = 0;
            if (adc_q.size() > 0) cur_word = adc_q.pop_front();
            else cur_word = {4'h0, 12'($urandom)};
         end
         if (!spi_ss_o) begin
            low_cnt++;
            if (!sck_prev && spi_sck_o) begin
               rises++;
               if (rises == 16) cap_full = rx_fifo_full_i;
            end
         end
         if (!ss_prev && spi_ss_o && enable_i) begin
            chk("frame_low_cycles", low_cnt, FRAME_LOW);
            chk("frame_sck_rises", rises, 16);
            if (cur_word[15:12] != 4'h0) m_ferr = 1;
            if (!m_phase) begin
               m_s0 = cur_word[11:0];
               m_phase = 1;
            end else begin
               m_phase = 0;
               if (cap_full) m_ovr = 1;
               else begin
                  m_data = {4'h0, cur_word[11:0], 4'h0, m_s0};
                  m_push = 1;
               end
            end
         end
         if (spi_ss_o) chk("sck_idle_high", 32'(spi_sck_o), 1);
         chk("push", 32'(sample_push_o), 32'(m_push));
         chk("data", sample_data_o, m_data);
         chk("overrun", 32'(overrun_o), 32'(m_ovr));
         chk("frame_err", 32'(frame_err_o), 32'(m_ferr));
         spi_miso_i = (!spi_ss_o && rises < 16) ? cur_word[4'(15 - rises)] : 1'b0;
         en_prev = enable_i; ss_prev = spi_ss_o; sck_prev = spi_sck_o;
      end
   end

   task automatic run_frames(input int n);
      int budget = n * SAMPLE_PERIOD + 200;
      int got = 0;
      logic prev = spi_ss_o;
      while (got < n && budget > 0) begin
         @(negedge clk_i);
         if (!prev && spi_ss_o) got++;
         prev = spi_ss_o;
         budget--;
      end
      chk("frame_timeout", got, n);
   endtask

   task automatic wait_rises(input int n);
      int budget = 2 * SAMPLE_PERIOD;
      int got = 0;
      logic prev;
      while (spi_ss_o && budget > 0) begin
         @(negedge clk_i);
         budget--;
      end
      prev = spi_sck_o;
      while (got < n && budget > 0) begin
         @(negedge clk_i);
         if (!prev && spi_sck_o) got++;
         prev = spi_sck_o;
         budget--;
      end
      chk("wait_sck_rises", got, n);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ss"}, 32'(spi_ss_o), 1);
      chk({tag, "_sck"}, 32'(spi_sck_o), 1);
      chk({tag, "_data"}, sample_data_o, 0);
      chk({tag, "_push"}, 32'(sample_push_o), 0);
      chk({tag, "_ovr"}, 32'(overrun_o), 0);
      chk({tag, "_ferr"}, 32'(frame_err_o), 0);
      chk({tag, "_fsm"}, 32'(fsm_st_o), 0);
   endtask

   initial begin
      logic [15:0] w0, w1;
      repeat (3) @(negedge clk_i);
      chk_reset_outputs("reset");
      rst_i = 1'b0;
      repeat (2) @(negedge clk_i);

      // Basic pair and start-up latency
      adc_q.push_back(16'h0ABC);
      adc_q.push_back(16'h0123);
      enable_i = 1'b1;
      @(negedge clk_i);
      chk("start_wait_fsm", 32'(fsm_st_o), 1);
      chk("start_wait_ss", 32'(spi_ss_o), 1);
      @(negedge clk_i);
      chk("start_conv_fsm", 32'(fsm_st_o), 2);
      chk("start_conv_ss", 32'(spi_ss_o), 0);
      chk("start_conv_sck", 32'(spi_sck_o), 0);
      run_frames(2);
      chk("basic_pair_data", sample_data_o, 32'h0123_0ABC);

      // Back-pressure drops the word and holds old data
      rx_fifo_full_i = 1'b1;
      adc_q.push_back(16'h0FFF);
      adc_q.push_back(16'h0001);
      run_frames(2);
      chk("bp_overrun", 32'(overrun_o), 1);
      chk("bp_data_held", sample_data_o, 32'h0123_0ABC);
      rx_fifo_full_i = 1'b0;
      adc_q.push_back(16'h0002);
      adc_q.push_back(16'h0003);
      run_frames(2);
      chk("bp_release_data", sample_data_o, 32'h0003_0002);

      // Nonzero leading nibble flags but still packs
      adc_q.push_back(16'h5ABC);
      adc_q.push_back(16'h0001);
      run_frames(2);
      chk("framing_err", 32'(frame_err_o), 1);
      chk("framing_data", sample_data_o, 32'h0001_0ABC);

      // Abort mid odd frame, then flags clear in IDLE
      adc_q.push_back(16'h0AAA);
      adc_q.push_back(16'h0BBB);
      run_frames(1);
      wait_rises(8);
      enable_i = 1'b0;
      @(negedge clk_i);
      chk("abort_ss", 32'(spi_ss_o), 1);
      chk("abort_sck", 32'(spi_sck_o), 1);
      chk("abort_fsm", 32'(fsm_st_o), 0);
      chk("abort_no_push", 32'(sample_push_o), 0);
      chk("abort_ovr_kept", 32'(overrun_o), 1);
      chk("abort_ferr_kept", 32'(frame_err_o), 1);
      @(negedge clk_i);
      chk("flag_clear_ovr", 32'(overrun_o), 0);
      chk("flag_clear_ferr", 32'(frame_err_o), 0);
      adc_q.delete();
      adc_q.push_back(16'h0111);
      adc_q.push_back(16'h0222);
      enable_i = 1'b1;
      run_frames(2);
      chk("reenable_data", sample_data_o, 32'h0222_0111);

      // Randomized pairs with random back-pressure, bad nibbles and aborts
      for (int it = 0; it < 10; it++) begin
         w0 = {($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, 12'($urandom)};
         w1 = {($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, 12'($urandom)};
         rx_fifo_full_i = ($urandom_range(0, 2) == 0);
         adc_q.push_back(w0);
         adc_q.push_back(w1);
         if ($urandom_range(0, 3) == 0) begin
            wait_rises($urandom_range(1, 15));
            enable_i = 1'b0;
            repeat (2) @(negedge clk_i);
            adc_q.delete();
            enable_i = 1'b1;
         end else begin
            run_frames(2);
         end
      end
      rx_fifo_full_i = 1'b0;

      // Reset in the middle of a frame
      wait_rises(3);
      rst_i = 1'b1;
      enable_i = 1'b0;
      @(negedge clk_i);
      chk_reset_outputs("midconv_reset");
      rst_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("post_reset_fsm", 32'(fsm_st_o), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/ad7476_sample_packer.md
# ad7476_sample_packer

Capture engine for the AD7476 12-bit serial ADC. It paces conversions with a programmable sample timer and drives the converter's chip-select and serial clock. It deserialises each 16-bit frame and packs two consecutive 12-bit samples into one 32-bit word. That word is pushed into the sensor receive FIFO held by the FPGA register block, on the same path that feeds the DMA engine. Control comes from the sensor-enable register bit and FIFO-full back-pressure.

## Interface
Parameters:
- SCLK_DIV, default 2: clk_i cycles per SCLK half-period (≥1).
- SAMPLE_PERIOD, default 80: clk_i cycles between successive chip-select falling edges. Must be ≥ 32*SCLK_DIV + QUIET_CYCLES + 2.
- QUIET_CYCLES, default 2: minimum clk_i cycles spi_ss_o stays high after a frame.

Ports:
- clk_i  in  1  WB_CLK domain clock. Single clock for the whole block.
- rst_i  in  1  Synchronous, active-high reset.
- enable_i  in  1  Sensor enable. Level-sensitive.
- rx_fifo_full_i  in  1  Receive FIFO full.
- spi_ss_o  out  1  ADC CSn, active low.
- spi_sck_o  out  1  ADC SCLK, idles high.
- spi_miso_i  in  1  ADC SDATA.
- sample_data_o  out  32  Packed word {4'h0, s1[11:0], 4'h0, s0[11:0]}.
- sample_push_o  out  1  One-cycle FIFO write strobe.
- overrun_o  out  1  Sticky: a word was dropped because the FIFO was full.
- frame_err_o  out  1  Sticky: a frame's 4 leading bits were not zero.
- fsm_st_o  out  2  Current state: IDLE=0, WAIT=1, CONV=2, QUIET=3.

## Operation
- Reset state: spi_ss_o=1, spi_sck_o=1, sample_data_o=0, sample_push_o=0, overrun_o=0, frame_err_o=0, fsm_st_o=IDLE. The pair phase and all counters are cleared.
- IDLE:
  - spi_ss_o and spi_sck_o are held high.
  - The sticky flags clear when enable_i is low in IDLE.
  - When enable_i=1, go to WAIT with the sample timer loaded so the first frame starts on the next cycle.
- Sample timer: counts 0..SAMPLE_PERIOD-1 and wraps. It runs continuously while enable_i=1 and is not restarted by frames.
- WAIT: when the timer reaches 0, go to CONV.
- CONV:
  - spi_ss_o=0 for exactly 32*SCLK_DIV cycles.
  - 16 bits, MSB first. Each bit is a low SCLK phase of SCLK_DIV cycles followed by a high phase of SCLK_DIV cycles.
  - spi_miso_i is sampled on the clk_i edge where spi_sck_o goes 0→1.
  - After the 16th high phase, go to QUIET.
- QUIET: spi_ss_o=1 for QUIET_CYCLES cycles, then go to WAIT.
- Frame handling: bits[15:12] are checked and any nonzero value sets frame_err_o. The sample is still used.
- Packing:
  - An even frame (pair phase 0) stores bits[11:0] into s0.
  - An odd frame stores s1 and completes the word.
- Push on word completion:
  - If rx_fifo_full_i=0: sample_data_o updates and sample_push_o pulses.
  - If rx_fifo_full_i=1: the word is discarded, sample_data_o holds its old value, and overrun_o is set.
  - In both cases the pair phase returns to 0.
- Abort: enable_i=0 in any state returns to IDLE on the next cycle.
  - spi_ss_o and spi_sck_o go high that cycle.
  - A held s0 is discarded and the pair phase is cleared.
  - No push occurs.
- rst_i has priority over everything, including an in-progress frame.

## Timing
- All outputs are registered.
- enable_i is sampled high at edge N (state is IDLE): WAIT at N+1, spi_ss_o=0 from N+2.
- Successive spi_ss_o falling edges are exactly SAMPLE_PERIOD cycles apart.
- spi_sck_o goes low on the same edge as spi_ss_o. The first rising edge is SCLK_DIV cycles later.
- Frame end: spi_ss_o rises on the edge after the 16th high phase completes.
- Push timing:
  - sample_push_o asserts on the same edge spi_ss_o rises after an odd frame.
  - sample_data_o is valid in that cycle and stable until the next push.
  - rx_fifo_full_i is sampled in the cycle the 16th bit is captured.
- Sticky flags set on the same edge as the (suppressed) push.

## Test plan
- Reset values: pulse rst_i mid-CONV → next cycle all outputs are at reset values, spi_ss_o=1, and fsm_st_o=0.
- Basic pair, SCLK_DIV=2, SAMPLE_PERIOD=80: ADC model returns 0x0ABC then 0x0123.
  - Exactly one push, with sample_data_o=0x0123_0ABC.
  - spi_ss_o is low for 64 cycles per frame.
  - Falling edges are 80 cycles apart.
  - 16 SCLK rising edges per frame.
- Back-pressure: hold rx_fifo_full_i=1 across a second pair 0x0FFF/0x0001.
  - No push, overrun_o=1, and sample_data_o stays 0x0123_0ABC.
  - Release full; the next pair 0x0002/0x0003 → push of 0x0003_0002.
- Framing: model returns 0x5ABC then 0x0001 → frame_err_o=1 and push of 0x0001_0ABC.
- Abort: deassert enable_i during bit 7 of the odd frame.
  - spi_ss_o and spi_sck_o are high the next cycle, with no push.
  - Re-enable with samples 0x0111/0x0222 → push of 0x0222_0111, confirming the stale s0 was discarded.
- Flag clear: with overrun_o=1 and enable_i=0 in IDLE → overrun_o=0 and frame_err_o=0 next cycle.
